// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and default widths for the ALU arbiter.
// Pure declarations: no latency, no flow control.
package alu_pkg;

    localparam int DAT_W = 144;

    localparam logic [3:0] OP_NONE  = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SPLIT = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_DEG   = 4'b0111;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_EVAL  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic logic op_legal(input logic [3:0] typ);
        case (typ)
            OP_ADD, OP_SPLIT, OP_MUL, OP_DIV, OP_DEG, OP_SHIFT, OP_EVAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a registered last-grant pointer.
// Latency: grant is combinational from req; backpressure: caller gates req when it cannot accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // High when requester 1 was granted last; reset so requester 0 wins the first tie.
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last_q)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_q <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one ALU, one op in flight; result strobed back to the owner.
// Latency: accept at 0, issue at 1, response one cycle after compute_done; no grant until RESP completes.
module alu_arbiter #(
    parameter int DAT_W = alu_pkg::DAT_W,
    parameter int TMO_W = 10
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req0_vld,
    output logic             req0_rdy,
    input  logic [3:0]       req0_typ,
    input  logic [0:DAT_W]   req0_o_dat,
    input  logic [0:DAT_W-1] req0_t_dat,
    input  logic             req0_mod_sel,
    input  logic [0:DAT_W]   req0_mod_dat,
    input  logic             req1_vld,
    output logic             req1_rdy,
    input  logic [3:0]       req1_typ,
    input  logic [0:DAT_W]   req1_o_dat,
    input  logic [0:DAT_W-1] req1_t_dat,
    input  logic             req1_mod_sel,
    input  logic [0:DAT_W]   req1_mod_dat,
    output logic             rsp0_vld,
    output logic             rsp1_vld,
    output logic [0:DAT_W-1] rsp_dat1,
    output logic [0:DAT_W-1] rsp_dat2,
    output logic             rsp_err,
    output logic [3:0]       alu_typ_sel,
    output logic             alu_o_sel,
    output logic             alu_t_sel,
    output logic             alu_mod_sel,
    output logic [0:DAT_W]   alu_o_dat,
    output logic [0:DAT_W-1] alu_t_dat,
    output logic [0:DAT_W]   alu_mod_dat,
    input  logic [0:DAT_W-1] alu_r_dat1,
    input  logic [0:DAT_W-1] alu_r_dat2,
    input  logic             compute_done
);

    import alu_pkg::*;

    // The counter hits its all-ones limit on the same edge that leaves WAIT.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_e             state_q;
    state_e             state_d;
    logic [1:0]         arb_req;
    logic [1:0]         gnt;
    logic               acc;
    logic               sel1;
    logic [3:0]         typ_in;
    logic               owner_q;
    logic               err_q;
    logic [3:0]         typ_q;
    logic [0:DAT_W]     o_q;
    logic [0:DAT_W-1]   t_q;
    logic               mod_sel_q;
    logic [0:DAT_W]     mod_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               done_ok;
    logic               tmo_hit;

    assign arb_req = {req1_vld, req0_vld} & {2{state_q == IDLE}};
    assign acc     = |gnt;
    assign sel1    = gnt[1];
    assign typ_in  = sel1 ? req1_typ : req0_typ;

    // A done strobe in the first WAIT cycle belongs to nothing we issued.
    assign done_ok = compute_done && (tmo_q != '0);
    assign tmo_hit = (tmo_q == TMO_LAST);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_b (rst_b),
        .req   (arb_req),
        .gnt   (gnt)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc) state_d = op_legal(typ_in) ? ISSUE : RESP;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done_ok || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            owner_q   <= 1'b0;
            err_q     <= 1'b0;
            typ_q     <= '0;
            o_q       <= '0;
            t_q       <= '0;
            mod_sel_q <= 1'b0;
            mod_q     <= '0;
            tmo_q     <= '0;
            rsp_dat1  <= '0;
            rsp_dat2  <= '0;
        end else begin
            if (acc) begin
                owner_q   <= sel1;
                err_q     <= !op_legal(typ_in);
                typ_q     <= typ_in;
                o_q       <= sel1 ? req1_o_dat   : req0_o_dat;
                t_q       <= sel1 ? req1_t_dat   : req0_t_dat;
                mod_sel_q <= sel1 ? req1_mod_sel : req0_mod_sel;
                mod_q     <= sel1 ? req1_mod_dat : req0_mod_dat;
            end else if (state_q == WAIT && !done_ok && tmo_hit) begin
                err_q <= 1'b1;
            end
            tmo_q <= (state_q == WAIT) ? tmo_q + TMO_W'(1) : '0;
            if (state_q == WAIT && done_ok) begin
                rsp_dat1 <= alu_r_dat1;
                rsp_dat2 <= alu_r_dat2;
            end
        end
    end

    always_comb begin
        req0_rdy    = gnt[0];
        req1_rdy    = gnt[1];
        rsp0_vld    = 1'b0;
        rsp1_vld    = 1'b0;
        rsp_err     = 1'b0;
        alu_typ_sel = OP_NONE;
        alu_o_sel   = 1'b0;
        alu_t_sel   = 1'b0;
        alu_mod_sel = 1'b0;
        alu_o_dat   = '0;
        alu_t_dat   = '0;
        alu_mod_dat = '0;
        case (state_q)
            ISSUE: begin
                alu_typ_sel = typ_q;
                alu_o_sel   = 1'b1;
                alu_t_sel   = 1'b1;
                alu_mod_sel = mod_sel_q;
                alu_o_dat   = o_q;
                alu_t_dat   = t_q;
                alu_mod_dat = mod_q;
            end
            WAIT: alu_typ_sel = typ_q;
            RESP: begin
                rsp0_vld = !owner_q;
                rsp1_vld = owner_q;
                rsp_err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a cycle-level ALU stand-in.
// Expected timing and results come from the op rules, not from DUT internals.
module tb_alu_arbiter;

    localparam int DAT_W   = 144;
    localparam int TMO_CYC = 1023;

    typedef logic [DAT_W:0]   long_t;
    typedef logic [DAT_W-1:0] short_t;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             req0_vld, req1_vld, req0_rdy, req1_rdy;
    logic [3:0]       req0_typ, req1_typ;
    logic [0:DAT_W]   req0_o_dat, req1_o_dat, req0_mod_dat, req1_mod_dat;
    logic [0:DAT_W-1] req0_t_dat, req1_t_dat;
    logic             req0_mod_sel, req1_mod_sel;
    logic             rsp0_vld, rsp1_vld, rsp_err;
    logic [0:DAT_W-1] rsp_dat1, rsp_dat2;
    logic [3:0]       alu_typ_sel;
    logic             alu_o_sel, alu_t_sel, alu_mod_sel;
    logic [0:DAT_W]   alu_o_dat, alu_mod_dat;
    logic [0:DAT_W-1] alu_t_dat;
    logic [0:DAT_W-1] alu_r_dat1, alu_r_dat2;
    logic             compute_done;

    int     n_asrt = 0;
    int     n_fail = 0;
    int     alu_lat = 3;
    int     alu_mode = 0;   // 0: done at cycle alu_lat, 1: never done, 2: done held high from first WAIT cycle
    short_t alu_res1, alu_res2;
    short_t exp_d1, exp_d2;
    int     rr_last = 1;
    logic [3:0] legal_ops [7] = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0111, 4'b1000, 4'b1001};

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_b(rst_b),
        .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_typ(req0_typ), .req0_o_dat(req0_o_dat),
        .req0_t_dat(req0_t_dat), .req0_mod_sel(req0_mod_sel), .req0_mod_dat(req0_mod_dat),
        .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_typ(req1_typ), .req1_o_dat(req1_o_dat),
        .req1_t_dat(req1_t_dat), .req1_mod_sel(req1_mod_sel), .req1_mod_dat(req1_mod_dat),
        .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld), .rsp_dat1(rsp_dat1), .rsp_dat2(rsp_dat2),
        .rsp_err(rsp_err), .alu_typ_sel(alu_typ_sel), .alu_o_sel(alu_o_sel), .alu_t_sel(alu_t_sel),
        .alu_mod_sel(alu_mod_sel), .alu_o_dat(alu_o_dat), .alu_t_dat(alu_t_dat),
        .alu_mod_dat(alu_mod_dat), .alu_r_dat1(alu_r_dat1), .alu_r_dat2(alu_r_dat2),
        .compute_done(compute_done)
    );

    function automatic long_t rand_long();
        long_t v = '0;
        for (int i = 0; i < 5; i++) v = (v << 32) | long_t'($urandom());
        return v;
    endfunction

    function automatic short_t rand_short();
        short_t v = '0;
        for (int i = 0; i < 5; i++) v = (v << 32) | short_t'($urandom());
        return v;
    endfunction

    task automatic check(input string tag, input long_t obs, input long_t expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_req(input int who, input logic v, input logic [3:0] typ, input long_t o,
                             input short_t t, input logic ms, input long_t m);
        if (who == 0) begin
            req0_vld = v; req0_typ = typ; req0_o_dat = o; req0_t_dat = t;
            req0_mod_sel = ms; req0_mod_dat = m;
        end else begin
            req1_vld = v; req1_typ = typ; req1_o_dat = o; req1_t_dat = t;
            req1_mod_sel = ms; req1_mod_dat = m;
        end
    endtask

    // ALU stand-in: real results only on the counted done cycle, junk otherwise.
    initial begin
        compute_done = 1'b0;
        alu_r_dat1   = '0;
        alu_r_dat2   = '0;
        forever begin
            @(negedge clk);
            if (alu_o_sel && alu_mode != 1) begin
                int k;
                k = (alu_mode == 2) ? 3 : alu_lat;
                for (int c = 2; c <= k; c++) begin
                    @(posedge clk); #1;
                    compute_done = (c == k) || (alu_mode == 2);
                    alu_r_dat1   = (c == k) ? alu_res1 : ~alu_res1;
                    alu_r_dat2   = (c == k) ? alu_res2 : ~alu_res2;
                end
                @(posedge clk); #1;
                compute_done = 1'b0;
                alu_r_dat1   = rand_short();
                alu_r_dat2   = rand_short();
            end
        end
    end

    task automatic run_txn(input int who, input logic [3:0] typ, input long_t o, input short_t t,
                           input long_t m, input logic ms, input int lat, input int mode);
        bit legal, seen, typ_ok, dat_ok, exp_err;
        int rel, issues, exp_rel;
        legal = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == typ) legal = 1'b1;
        alu_lat  = lat;
        alu_mode = mode;
        alu_res1 = rand_short();
        alu_res2 = rand_short();
        @(posedge clk); #1;
        drive_req(who, 1'b1, typ, o, t, ms, m);
        @(negedge clk);
        check("accept_rdy", (who == 0) ? req0_rdy : req1_rdy, 1);
        check("other_rdy", (who == 0) ? req1_rdy : req0_rdy, 0);
        @(posedge clk); #1;
        drive_req(who, 1'b0, $urandom_range(0, 15), rand_long(), rand_short(), ~ms, rand_long());
        rel = 1; seen = 0; issues = 0; typ_ok = 1; dat_ok = 1;
        while (!seen && rel < 1200) begin
            @(negedge clk);
            if (alu_o_sel) begin
                issues++;
                if (rel != 1 || alu_o_dat !== o || alu_t_dat !== t || alu_t_sel !== 1'b1 ||
                    alu_mod_sel !== ms || alu_mod_dat !== m) dat_ok = 0;
            end
            seen = rsp0_vld | rsp1_vld;
            if (alu_typ_sel !== ((seen || !legal) ? 4'b0000 : typ)) typ_ok = 0;
            if (!seen) rel++;
        end
        exp_rel = !legal ? 1 : (mode == 1) ? 2 + TMO_CYC : (mode == 2) ? 4 : lat + 1;
        exp_err = !legal || (mode == 1);
        if (legal && mode != 1) begin
            exp_d1 = alu_res1;
            exp_d2 = alu_res2;
        end
        check("rsp_seen", seen, 1);
        check("rsp_cycle", rel, exp_rel);
        check("issue_count", issues, legal ? 1 : 0);
        check("issue_data", dat_ok, 1);
        check("typ_sel", typ_ok, 1);
        check("rsp_owner", (who == 0) ? rsp0_vld : rsp1_vld, 1);
        check("rsp_other", (who == 0) ? rsp1_vld : rsp0_vld, 0);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_dat1", rsp_dat1, exp_d1);
        check("rsp_dat2", rsp_dat2, exp_d2);
        @(negedge clk);
        check("rsp_one_cycle", rsp0_vld | rsp1_vld, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int owners[$];
        int got, budget, o_exp;
        rst_b = 1'b1;
        drive_req(0, 1'b0, 4'b0000, '0, '0, 1'b0, '0);
        drive_req(1, 1'b0, 4'b0000, '0, '0, 1'b0, '0);
        exp_d1 = '0;
        exp_d2 = '0;
        #1 rst_b = 1'b0;
        #1;
        check("rst_rsp_vld", {rsp0_vld, rsp1_vld}, 0);
        check("rst_alu_sel", {alu_o_sel, alu_t_sel, alu_mod_sel}, 0);
        check("rst_typ_sel", alu_typ_sel, 0);
        check("rst_rsp_dat", {rsp_dat1, rsp_dat2}, 0);
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        check("idle_rdy", {req0_rdy, req1_rdy}, 0);
        check("idle_err", rsp_err, 0);
        check("idle_o_dat", alu_o_dat, 0);

        // Continuous contention straight out of reset.
        alu_lat  = 3;
        alu_mode = 0;
        alu_res1 = rand_short();
        alu_res2 = rand_short();
        @(posedge clk); #1;
        drive_req(0, 1'b1, 4'b0001, rand_long(), rand_short(), 1'b0, rand_long());
        drive_req(1, 1'b1, 4'b0011, rand_long(), rand_short(), 1'b0, rand_long());
        for (int g = 0; g < 4; g++) begin
            got = -1;
            budget = 0;
            while (got < 0 && budget < 20) begin
                @(negedge clk);
                budget++;
                if ((rsp0_vld | rsp1_vld) && owners.size() > 0) begin
                    o_exp = owners.pop_front();
                    check("rr_rsp_owner", rsp1_vld, (o_exp == 1));
                end
                if (req0_rdy | req1_rdy) begin
                    check("rr_one_hot", req0_rdy & req1_rdy, 0);
                    got = int'(req1_rdy);
                end
            end
            // Both valid: the requester not granted last wins.
            check("rr_grant", got, (rr_last == 0) ? 1 : 0);
            owners.push_back(got);
            rr_last = got;
        end
        @(posedge clk); #1;
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        budget = 0;
        while (owners.size() > 0 && budget < 30) begin
            @(negedge clk);
            budget++;
            if (rsp0_vld | rsp1_vld) begin
                o_exp = owners.pop_front();
                check("rr_rsp_owner", rsp1_vld, (o_exp == 1));
            end
        end
        check("rr_drain", owners.size(), 0);
        exp_d1 = alu_res1;
        exp_d2 = alu_res2;
        check("rr_rsp_dat1", rsp_dat1, exp_d1);

        run_txn(0, 4'b0001, long_t'(16'hfff1), short_t'(16'h0f0f), rand_long(), 1'b0, 5, 0);
        run_txn(1, 4'b0100, rand_long(), rand_short(), rand_long(), 1'b0, 4, 0);
        run_txn(0, 4'b0010, rand_long(), rand_short(), rand_long(), 1'b0, 3, 2);
        run_txn(1, 4'b0111, rand_long(), rand_short(), rand_long(), 1'b0, 3, 1);

        // Reset in the middle of a div WAIT.
        alu_lat  = 20;
        alu_mode = 0;
        alu_res1 = rand_short();
        alu_res2 = rand_short();
        @(posedge clk); #1;
        drive_req(0, 1'b1, 4'b0101, rand_long(), rand_short(), 1'b0, rand_long());
        @(negedge clk);
        check("div_rdy", req0_rdy, 1);
        @(posedge clk); #1;
        req0_vld = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("div_wait_typ", alu_typ_sel, 4'b0101);
        @(posedge clk); #3;
        rst_b = 1'b0;
        #1;
        check("rst_mid_typ", alu_typ_sel, 0);
        check("rst_mid_rsp", {rsp0_vld, rsp1_vld, rsp_err}, 0);
        check("rst_mid_dat", {rsp_dat1, rsp_dat2}, 0);
        check("rst_mid_sel", {alu_o_sel, alu_t_sel, alu_mod_sel}, 0);
        repeat (25) @(posedge clk);
        #1 rst_b = 1'b1;
        exp_d1 = '0;
        exp_d2 = '0;
        run_txn(1, 4'b0011, rand_long(), rand_short(), rand_long(), 1'b1, 6, 0);

        for (int i = 0; i < 12; i++) begin
            run_txn($urandom_range(0, 1), 4'($urandom_range(0, 15)), rand_long(), rand_short(),
                    rand_long(), 1'($urandom_range(0, 1)), $urandom_range(3, 12),
                    ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
